hdbn_substitute: RTL and testbench



---
 rtl/hdb_pkg.sv | 13 +
 rtl/hdbn_substitute.sv | 116 +++++++++++
 tb/tb_hdbn_substitute.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hdb_pkg.sv
// Symbol codes shared by the HDBn substitution and polarity stages.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package hdb_pkg;

    typedef logic [1:0] hdb_sym_t;

    localparam hdb_sym_t SYM_ZERO = 2'b00;
    localparam hdb_sym_t SYM_ONE  = 2'b01;
    localparam hdb_sym_t SYM_V    = 2'b10;
    localparam hdb_sym_t SYM_B    = 2'b11;

endpackage : hdb_pkg

// File: rtl/hdbn_substitute.sv
// HDBn substitution: serial bits in, 2-bit symbols out with V/B pulses inserted.
// Latency: symbol of accept k appears (dout_valid=1) the cycle after accept k+N+1.
// Backpressure: none; din_valid=0 stalls freeze all state, output strobes drop.
module hdbn_substitute
    import hdb_pkg::*;
#(
    parameter int N        = 3,
    parameter bit INIT_ODD = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic       din_valid,
    input  logic       hdb_en,
    output logic [1:0] dout,
    output logic       dout_valid,
    output logic       subst_pulse
);

    localparam int ZW = $clog2(N + 1);
    localparam int FW = $clog2(N + 2);
    localparam logic [ZW-1:0] ZCNT_MAX  = ZW'(N);
    localparam logic [FW-1:0] FILL_FULL = FW'(N + 1);

    // Delay line is N+1 deep so the first zero of a run is still on board when
    // the completing zero arrives and a B may be written over it.
    hdb_sym_t        sr_q [0:N];
    hdb_sym_t        sr_d [0:N];
    logic [ZW-1:0]   zcnt_q, zcnt_d;
    logic            par_q, par_d;
    logic [FW-1:0]   fill_q, fill_d;
    hdb_sym_t        dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            subst_pulse_q, subst_pulse_d;

    logic            subst;
    hdb_sym_t        new_sym;

    // Next-symbol selection and next-state of line, counters and outputs.
    always_comb begin
        subst   = din_valid && hdb_en && !din && (zcnt_q == ZCNT_MAX);
        new_sym = din ? SYM_ONE : SYM_ZERO;
        if (subst) begin
            new_sym = SYM_V;
        end

        sr_d          = sr_q;
        zcnt_d        = zcnt_q;
        par_d         = par_q;
        fill_d        = fill_q;
        dout_d        = dout_q;
        dout_valid_d  = 1'b0;
        subst_pulse_d = 1'b0;

        if (din_valid) begin
            dout_d        = sr_q[N];
            dout_valid_d  = (fill_q == FILL_FULL);
            subst_pulse_d = subst;

            for (int k = 1; k <= N; k++) begin
                sr_d[k] = sr_q[k-1];
            end
            sr_d[0] = new_sym;
            // Even parity since the last V: balance with a B on the run's first zero.
            if (subst && !par_q) begin
                sr_d[N] = SYM_B;
            end

            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FW'(1);
            end

            if (!hdb_en || din || subst) begin
                zcnt_d = '0;
            end else begin
                zcnt_d = zcnt_q + ZW'(1);
            end

            if (subst) begin
                par_d = 1'b0;
            end else if (din) begin
                par_d = ~par_q;
            end
        end
    end

    // State registers; reset discards the line and any partial run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= N; k++) begin
                sr_q[k] <= SYM_ZERO;
            end
            zcnt_q        <= '0;
            par_q         <= INIT_ODD;
            fill_q        <= '0;
            dout_q        <= SYM_ZERO;
            dout_valid_q  <= 1'b0;
            subst_pulse_q <= 1'b0;
        end else begin
            for (int k = 0; k <= N; k++) begin
                sr_q[k] <= sr_d[k];
            end
            zcnt_q        <= zcnt_d;
            par_q         <= par_d;
            fill_q        <= fill_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            subst_pulse_q <= subst_pulse_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign subst_pulse = subst_pulse_q;

endmodule : hdbn_substitute

// File: tb/tb_hdbn_substitute.sv
// Directed bench for hdbn_substitute with N=3 and N=4 instances on shared stimulus.
// Latency: expected symbols are indexed by input position, outputs collected in order.
// Backpressure: none; gaps between accepts are exercised.
module tb_hdbn_substitute;
    import hdb_pkg::*;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       din       = 1'b0;
    logic       din_valid = 1'b0;
    logic       hdb_en    = 1'b1;
    logic [1:0] dout3, dout4;
    logic       dv3, dv4, sp3, sp4;

    always #5 clk = ~clk;

    hdbn_substitute #(.N(3), .INIT_ODD(1'b1)) dut3 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .hdb_en(hdb_en),
        .dout(dout3), .dout_valid(dv3), .subst_pulse(sp3)
    );

    hdbn_substitute #(.N(4), .INIT_ODD(1'b1)) dut4 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .hdb_en(hdb_en),
        .dout(dout4), .dout_valid(dv4), .subst_pulse(sp4)
    );

    typedef struct {
        int         ph;
        logic       d;
        logic       en;
        logic [1:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [1:0] q3[$], q4[$];
    logic [1:0] last3 = 2'b00, last4 = 2'b00;
    int         sp3_cnt, sp4_cnt, dv3_cnt, dv4_cnt;
    int         first_dv3 = -1, first_dv4 = -1;
    int         acc;
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int ph, input logic d, input logic en, input logic [1:0] e);
        vec_t v;
        v.ph = ph; v.d = d; v.en = en; v.exp = e;
        tbl.push_back(v);
    endfunction

    // Bench-side accept counter, used to locate the first output strobe.
    always @(posedge clk or posedge reset) begin
        if (reset) acc <= 0;
        else if (din_valid) acc <= acc + 1;
    end

    // Output monitor: collect strobed symbols, count pulses, check dout holds between strobes.
    always @(negedge clk) begin
        if (reset) begin
            last3 = 2'b00;
            last4 = 2'b00;
        end else begin
            if (dv3) begin
                q3.push_back(dout3); last3 = dout3; dv3_cnt++;
                if (first_dv3 < 0) first_dv3 = acc;
            end else begin
                chk("hold3", dout3, last3);
            end
            if (dv4) begin
                q4.push_back(dout4); last4 = dout4; dv4_cnt++;
                if (first_dv4 < 0) first_dv4 = acc;
            end else begin
                chk("hold4", dout4, last4);
            end
            if (sp3) sp3_cnt++;
            if (sp4) sp4_cnt++;
        end
    end

    task automatic do_reset();
        din_valid = 1'b0; din = 1'b0; hdb_en = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("rst_dout3", dout3, 0); chk("rst_dv3", dv3, 0); chk("rst_sp3", sp3, 0);
        chk("rst_dout4", dout4, 0); chk("rst_dv4", dv4, 0); chk("rst_sp4", sp4, 0);
        q3.delete(); q4.delete();
        sp3_cnt = 0; sp4_cnt = 0; dv3_cnt = 0; dv4_cnt = 0;
        first_dv3 = -1; first_dv4 = -1;
        reset = 1'b0;
    endtask

    task automatic send(input logic b, input logic en, input int gap);
        din = b; hdb_en = en; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_phase(input int ph, input int gap, input int nsel, input int exp_sp);
        int         n = 0;
        int         j = 0;
        logic [1:0] q[$];
        do_reset();
        foreach (tbl[i]) if (tbl[i].ph == ph) begin
            send(tbl[i].d, tbl[i].en, gap);
            n++;
        end
        repeat (5) send(1'b1, 1'b1, gap);
        repeat (3) @(negedge clk);
        if (nsel == 4) q = q4; else q = q3;
        foreach (tbl[i]) if (tbl[i].ph == ph) begin
            if (j < q.size()) chk($sformatf("ph%0d_sym%0d", ph, j), q[j], tbl[i].exp);
            else chk($sformatf("ph%0d_missing%0d", ph, j), -1, tbl[i].exp);
            j++;
        end
        if (nsel == 4) begin
            chk($sformatf("ph%0d_dv_count", ph), dv4_cnt, n + 5 - 5);
            chk($sformatf("ph%0d_subst_count", ph), sp4_cnt, exp_sp);
        end else begin
            chk($sformatf("ph%0d_dv_count", ph), dv3_cnt, n + 5 - 4);
            chk($sformatf("ph%0d_subst_count", ph), sp3_cnt, exp_sp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Phase 1 (N=3): two back-to-back runs, then odd parity, then even parity.
        add(1,0,1,2'b00); add(1,0,1,2'b00); add(1,0,1,2'b00); add(1,0,1,2'b10);
        add(1,0,1,2'b11); add(1,0,1,2'b00); add(1,0,1,2'b00); add(1,0,1,2'b10);
        add(1,1,1,2'b01); add(1,0,1,2'b00); add(1,0,1,2'b00); add(1,0,1,2'b00); add(1,0,1,2'b10);
        add(1,1,1,2'b01); add(1,1,1,2'b01);
        add(1,0,1,2'b11); add(1,0,1,2'b00); add(1,0,1,2'b00); add(1,0,1,2'b10);
        // Phase 2 (N=3): first scenario again, applied with gaps.
        add(2,0,1,2'b00); add(2,0,1,2'b00); add(2,0,1,2'b00); add(2,0,1,2'b10);
        add(2,0,1,2'b11); add(2,0,1,2'b00); add(2,0,1,2'b00); add(2,0,1,2'b10);
        // Phase 3 (N=3): bypass 8 zeros + mark (par now even), then a substituted run.
        for (int i = 0; i < 8; i++) add(3,0,0,2'b00);
        add(3,1,0,2'b01);
        add(3,0,1,2'b11); add(3,0,1,2'b00); add(3,0,1,2'b00); add(3,0,1,2'b10);
        // Phase 4 (N=4): two 5-zero runs.
        add(4,0,1,2'b00); add(4,0,1,2'b00); add(4,0,1,2'b00); add(4,0,1,2'b00); add(4,0,1,2'b10);
        add(4,0,1,2'b11); add(4,0,1,2'b00); add(4,0,1,2'b00); add(4,0,1,2'b00); add(4,0,1,2'b10);
        // Phase 6 (N=3): hdb_en drops mid-run, so the count restarts.
        add(6,0,1,2'b00); add(6,0,1,2'b00); add(6,0,0,2'b00);
        add(6,0,1,2'b00); add(6,0,1,2'b00); add(6,0,1,2'b00); add(6,0,1,2'b10);

        run_phase(1, 0, 3, 4);
        run_phase(2, 2, 3, 2);
        run_phase(3, 0, 3, 1);
        run_phase(4, 0, 4, 2);
        run_phase(6, 1, 3, 1);

        // Phase 5: reset in the middle of a run, then a short mark-only stream.
        do_reset();
        send(1'b0, 1'b1, 0);
        send(1'b0, 1'b1, 0);
        do_reset();
        send(1'b0, 1'b1, 0); send(1'b0, 1'b1, 0);
        send(1'b1, 1'b1, 0); send(1'b1, 1'b1, 0); send(1'b1, 1'b1, 0);
        repeat (5) send(1'b1, 1'b1, 0);
        repeat (3) @(negedge clk);
        chk("ph5_first_dv3", first_dv3, 5);
        chk("ph5_first_dv4", first_dv4, 6);
        chk("ph5_subst3", sp3_cnt, 0);
        chk("ph5_subst4", sp4_cnt, 0);
        chk("ph5_count3", q3.size(), 6);
        chk("ph5_count4", q4.size(), 5);
        if (q3.size() >= 5) begin
            chk("ph5_sym0", q3[0], 0); chk("ph5_sym1", q3[1], 0);
            chk("ph5_sym2", q3[2], 1); chk("ph5_sym3", q3[3], 1); chk("ph5_sym4", q3[4], 1);
        end
        foreach (q4[i]) chk($sformatf("ph5_n4_noVB%0d", i), int'(q4[i][1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hdbn_substitute
